// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one ALU between two valid/ready requesters
package alu_share_pkg;
  typedef logic [31:0] word;
  typedef logic [3:0] alu_op_t;
  localparam alu_op_t OP_ADD  = 4'd0;
  localparam alu_op_t OP_SUB  = 4'd1;
  localparam alu_op_t OP_SLL  = 4'd2;
  localparam alu_op_t OP_SLT  = 4'd3;
  localparam alu_op_t OP_SLTU = 4'd4;
  localparam alu_op_t OP_XOR  = 4'd5;
  localparam alu_op_t OP_SRL  = 4'd6;
  localparam alu_op_t OP_SRA  = 4'd7;
  localparam alu_op_t OP_OR   = 4'd8;
  localparam alu_op_t OP_AND  = 4'd9;
endpackage

module alu_rtl
  import alu_share_pkg::*;
(
  input  alu_op_t op,
  input  word     a,
  input  word     b,
  output word     out
);
  always_comb begin
    case (op)
      OP_ADD:  out = a + b;
      OP_SUB:  out = a - b;
      OP_SLL:  out = a << b[4:0];
      OP_SLT:  out = {31'd0, $signed(a) < $signed(b)};
      OP_SLTU: out = {31'd0, a < b};
      OP_XOR:  out = a ^ b;
      OP_SRL:  out = a >> b[4:0];
      OP_SRA:  out = word'($signed(a) >>> b[4:0]);
      OP_OR:   out = a | b;
      OP_AND:  out = a & b;
      default: out = '0;
    endcase
  end
endmodule

module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter bit PRIO_RESET = 1'b0
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    req_valid_0,
  input  logic    req_valid_1,
  output logic    req_ready_0,
  output logic    req_ready_1,
  input  alu_op_t req_op_0,
  input  alu_op_t req_op_1,
  input  word     req_a_0,
  input  word     req_a_1,
  input  word     req_b_0,
  input  word     req_b_1,
  output logic    rsp_valid_0,
  output logic    rsp_valid_1,
  input  logic    rsp_ready_0,
  input  logic    rsp_ready_1,
  output word     rsp_data_0,
  output word     rsp_data_1,
  output logic    busy
);
  typedef enum logic {IDLE, RESP} state_t;
  state_t state, state_nx;
  logic grant, hs, owner, last_served, retire;
  word alu_out, rsp_data_reg;
  alu_rtl u_alu (
    .op (grant ? req_op_1 : req_op_0),
    .a  (grant ? req_a_1  : req_a_0),
    .b  (grant ? req_b_1  : req_b_0),
    .out(alu_out)
  );
  // rst_n gates the handshake so no ready escapes while reset is held
  always_comb begin
    grant  = (req_valid_0 && req_valid_1) ? ~last_served : req_valid_1;
    hs     = (state == IDLE) && rst_n && (req_valid_0 || req_valid_1);
    retire = (state == RESP) && (owner ? rsp_ready_1 : rsp_ready_0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end
  always_comb begin
    state_nx = (state == IDLE) ? (hs ? RESP : IDLE) : (retire ? IDLE : RESP);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data_reg <= '0;
      owner        <= 1'b0;
      last_served  <= ~PRIO_RESET;
    end else begin
      if (hs) begin
        rsp_data_reg <= alu_out;
        owner        <= grant;
      end
      if (retire) last_served <= owner;
    end
  end
  always_comb begin
    req_ready_0 = hs && !grant;
    req_ready_1 = hs && grant;
    rsp_valid_0 = (state == RESP) && !owner;
    rsp_valid_1 = (state == RESP) && owner;
    rsp_data_0  = rsp_valid_0 ? rsp_data_reg : '0;
    rsp_data_1  = rsp_valid_1 ? rsp_data_reg : '0;
    busy        = (state == RESP);
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: table vectors plus scoreboard-checked corner sequences
module tb_alu_share_arbiter;
  import alu_share_pkg::*;
  logic clk, rst_n;
  logic req_valid_0, req_valid_1, req_ready_0, req_ready_1;
  logic [3:0] req_op_0, req_op_1;
  logic [31:0] req_a_0, req_a_1, req_b_0, req_b_1;
  logic rsp_valid_0, rsp_valid_1, rsp_ready_0, rsp_ready_1, busy;
  logic [31:0] rsp_data_0, rsp_data_1;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {logic p; logic [31:0] d;} exp_t;
  exp_t sb[$];
  typedef struct {logic p; logic [3:0] op; logic [31:0] a, b, exp;} vec_t;
  vec_t vecs[12];

  alu_share_arbiter #(.PRIO_RESET(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_op_0(req_op_0), .req_op_1(req_op_1),
    .req_a_0(req_a_0), .req_a_1(req_a_1),
    .req_b_0(req_b_0), .req_b_1(req_b_1),
    .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
    .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
    .rsp_data_0(rsp_data_0), .rsp_data_1(rsp_data_1),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pop_chk(input logic p, input logic [31:0] d, input logic [31:0] other);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_unexpected: got response on port %0d data %h expected none", p, d);
    end else begin
      e = sb.pop_front();
      chk("rsp_port", 32'(p), 32'(e.p));
      chk("rsp_data", d, e.d);
      chk("rsp_nonowner_data", other, 32'd0);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    if (rsp_valid_0 && rsp_ready_0) pop_chk(1'b0, rsp_data_0, rsp_data_1);
    if (rsp_valid_1 && rsp_ready_1) pop_chk(1'b1, rsp_data_1, rsp_data_0);
  end

  task automatic drive(input logic p, input logic [3:0] op, input logic [31:0] a, b);
    if (p) begin req_op_1 = op; req_a_1 = a; req_b_1 = b; req_valid_1 = 1'b1; end
    else   begin req_op_0 = op; req_a_0 = a; req_b_0 = b; req_valid_0 = 1'b1; end
  endtask

  task automatic await(input logic p, input logic [31:0] exp);
    int n = 0;
    @(negedge clk);
    while (!(p ? req_ready_1 : req_ready_0) && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: port %0d got no ready expected ready within 50 cycles", p);
    end else sb.push_back('{p, exp});
    @(posedge clk) #1;
    if (p) req_valid_1 = 1'b0; else req_valid_0 = 1'b0;
  endtask

  task automatic send(input logic p, input logic [3:0] op, input logic [31:0] a, b, exp);
    @(posedge clk) #1;
    drive(p, op, a, b);
    await(p, exp);
    @(negedge clk);
    chk("latency_valid", 32'(p ? rsp_valid_1 : rsp_valid_0), 32'd1);
  endtask

  task automatic drain;
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      n++;
      @(posedge clk);
    end
    chk("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    vecs = '{
      '{1'b0, OP_ADD,  32'd5,        32'd7,        32'd12},
      '{1'b1, OP_SLT,  32'hFFFFFFFF, 32'd1,        32'd1},
      '{1'b0, OP_SRA,  32'h80000000, 32'd4,        32'hF8000000},
      '{1'b1, OP_SLTU, 32'd1,        32'hFFFFFFFF, 32'd1},
      '{1'b0, OP_SLL,  32'd1,        32'd31,       32'h80000000},
      '{1'b1, OP_SUB,  32'd3,        32'd5,        32'hFFFFFFFE},
      '{1'b0, OP_XOR,  32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F},
      '{1'b1, OP_AND,  32'hF0F01234, 32'h0FF0FFFF, 32'h00F01234},
      '{1'b0, OP_OR,   32'h00FF0000, 32'h000000FF, 32'h00FF00FF},
      '{1'b1, OP_SRL,  32'h80000000, 32'd4,        32'h08000000},
      '{1'b0, OP_SLTU, 32'hFFFFFFFF, 32'd1,        32'd0},
      '{1'b1, OP_ADD,  32'hFFFFFFFF, 32'd1,        32'd0}
    };
    rst_n = 1'b0;
    req_valid_0 = 1'b1; req_valid_1 = 1'b1;
    req_op_0 = OP_ADD; req_op_1 = OP_ADD;
    req_a_0 = '0; req_a_1 = '0; req_b_0 = '0; req_b_1 = '0;
    rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
    @(negedge clk);
    chk("rst_req_ready_0", 32'(req_ready_0), 32'd0);
    chk("rst_req_ready_1", 32'(req_ready_1), 32'd0);
    chk("rst_rsp_valid_0", 32'(rsp_valid_0), 32'd0);
    chk("rst_rsp_valid_1", 32'(rsp_valid_1), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_data_0", rsp_data_0, 32'd0);
    @(posedge clk) #1;
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      send(vecs[i].p, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
      drain();
    end

    // tie after reset: PRIO_RESET=0 wins first, then alternation
    @(posedge clk) #1;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    drive(1'b0, OP_SUB, 32'd10, 32'd3);
    drive(1'b1, OP_SLT, 32'hFFFFFFFF, 32'd1);
    @(negedge clk);
    chk("tie_ready_0", 32'(req_ready_0), 32'd1);
    chk("tie_ready_1", 32'(req_ready_1), 32'd0);
    sb.push_back('{1'b0, 32'd7});
    @(posedge clk) #1;
    req_valid_0 = 1'b0;
    await(1'b1, 32'd1);
    drive(1'b0, OP_SUB, 32'd10, 32'd3);
    drive(1'b1, OP_SLT, 32'hFFFFFFFF, 32'd1);
    @(negedge clk);
    chk("resp_stall_ready_0", 32'(req_ready_0), 32'd0);
    chk("resp_stall_ready_1", 32'(req_ready_1), 32'd0);
    @(negedge clk);
    chk("rr_ready_0", 32'(req_ready_0), 32'd1);
    chk("rr_ready_1", 32'(req_ready_1), 32'd0);
    sb.push_back('{1'b0, 32'd7});
    @(posedge clk) #1;
    req_valid_0 = 1'b0;
    await(1'b1, 32'd1);
    drain();

    // backpressure on port 1 while port 0 waits
    @(posedge clk) #1;
    rsp_ready_1 = 1'b0;
    drive(1'b1, OP_XOR, 32'hFF00FF00, 32'h0F0F0F0F);
    await(1'b1, 32'hF00FF00F);
    drive(1'b0, OP_ADD, 32'd1, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_valid_1", 32'(rsp_valid_1), 32'd1);
      chk("bp_data_1", rsp_data_1, 32'hF00FF00F);
      chk("bp_busy", 32'(busy), 32'd1);
      chk("bp_ready_0", 32'(req_ready_0), 32'd0);
    end
    @(posedge clk) #1;
    rsp_ready_1 = 1'b1;
    await(1'b0, 32'd2);
    drain();

    // reset while a result is held
    @(posedge clk) #1;
    rsp_ready_0 = 1'b0;
    drive(1'b0, OP_ADD, 32'd5, 32'd7);
    await(1'b0, 32'd12);
    @(negedge clk);
    chk("mid_valid_before", 32'(rsp_valid_0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_valid_async", 32'(rsp_valid_0), 32'd0);
    chk("mid_busy_async", 32'(busy), 32'd0);
    sb.delete();
    rsp_ready_0 = 1'b1;
    drive(1'b0, OP_ADD, 32'd2, 32'd3);
    drive(1'b1, OP_SUB, 32'd9, 32'd4);
    #1;
    chk("mid_rst_ready_0", 32'(req_ready_0), 32'd0);
    chk("mid_rst_ready_1", 32'(req_ready_1), 32'd0);
    @(posedge clk) #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready_0", 32'(req_ready_0), 32'd1);
    chk("post_rst_ready_1", 32'(req_ready_1), 32'd0);
    sb.push_back('{1'b0, 32'd5});
    @(posedge clk) #1;
    req_valid_0 = 1'b0;
    await(1'b1, 32'd5);
    drain();

    // back-to-back streaming on port 0
    begin
      int last = 0, n;
      @(posedge clk) #1;
      drive(1'b0, OP_ADD, 32'd0, 32'd100);
      for (int i = 0; i < 6; i++) begin
        n = 0;
        @(negedge clk);
        while (!req_ready_0 && n < 20) begin
          n++;
          @(negedge clk);
        end
        if (i > 0) chk("stream_interval", 32'(cyc - last), 32'd2);
        last = cyc;
        sb.push_back('{1'b0, 32'(i * 3 + 100)});
        @(posedge clk) #1;
        req_a_0 = 32'((i + 1) * 3);
      end
      req_valid_0 = 1'b0;
    end
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish by 200000");
    $fatal(1);
  end
endmodule
